imem_loader: RTL and testbench

- Write-side counterpart of the byte-addressable, big-endian instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and writes each word as 4 byte writes, MSB byte at the lowest address.
- A memory image written this way reads back through the existing big-endian fetch port unchanged.
- Sits between the boot/debug stream source and the program memory's write port.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_loader.sv | 90 +++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the big-endian instruction memory reader and writer.
package imem_pkg;

  localparam int unsigned IMEM_SIZE_DEFAULT = 4096;
  localparam int unsigned BYTES_PER_INSTR   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_e;

  // Byte idx 0 is the most significant byte (lowest address).
  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into byte-wide program memory, MSB byte first,
// so the image reads back unchanged through the big-endian fetch port.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned IMEM_SIZE = IMEM_SIZE_DEFAULT,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      base_addr,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic             in_last,
  output logic             in_ready,
  output logic             mem_we,
  output logic [63:0]      mem_waddr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [63:0] LAST_BASE = 64'(IMEM_SIZE - BYTES_PER_INSTR);

  state_e           state;
  logic [63:0]      addr;
  logic [31:0]      word;
  logic             last;
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      word     <= '0;
      last     <= 1'b0;
      byte_idx <= '0;
      count    <= '0;
    end else begin
      unique case (state)
        IDLE, ERROR: begin
          if (start) begin
            if (base_addr[1:0] != 2'b00) begin
              state <= ERROR;
            end else begin
              addr  <= base_addr;
              count <= '0;
              state <= ACCEPT;
            end
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            word     <= in_instr;
            last     <= in_last;
            byte_idx <= '0;
            // Bounds check happens before any byte is written, so addr never wraps.
            state    <= (addr > LAST_BASE) ? ERROR : WRITE;
          end
        end
        WRITE: begin
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            addr <= addr + 64'(BYTES_PER_INSTR);
            if (count != '1) count <= count + 1'b1;
            state <= last ? DONE : ACCEPT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready   = (state == ACCEPT);
    mem_we     = (state == WRITE);
    mem_waddr  = mem_we ? addr + {62'b0, byte_idx} : '0;
    mem_wdata  = mem_we ? be_byte(word, byte_idx) : '0;
    busy       = (state == ACCEPT) || (state == WRITE);
    done       = (state == DONE);
    error      = (state == ERROR);
    word_count = count;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a transaction-level model predicts every
// output each cycle; directed scenarios add literal checks on the model.
module tb_imem_loader;

  localparam int unsigned SIZE = 4096;
  localparam int unsigned CW   = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [63:0]   base_addr = '0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_instr = '0;
  logic          in_last = 1'b0;
  logic          in_ready, mem_we, busy, done, error;
  logic [63:0]   mem_waddr;
  logic [7:0]    mem_wdata;
  logic [CW-1:0] word_count;

  imem_loader #(.IMEM_SIZE(SIZE), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_instr(in_instr), .in_last(in_last),
    .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: session flags plus a countdown of bytes still to be written.
  bit              m_acc, m_err, m_done, m_last;
  int              m_left;
  longint unsigned m_addr;
  logic [31:0]     m_word;
  int              m_count;

  always @(posedge clk) begin
    if (reset) begin
      m_acc = 0; m_err = 0; m_done = 0; m_last = 0;
      m_left = 0; m_addr = 0; m_word = '0; m_count = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_addr = m_addr + 4;
        if (m_count < (1 << CW) - 1) m_count = m_count + 1;
        if (m_last) m_done = 1; else m_acc = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (m_acc) begin
      if (in_valid) begin
        m_acc  = 0;
        m_word = in_instr;
        m_last = in_last;
        if (m_addr + 4 > SIZE) m_err = 1;
        else m_left = 4;
      end
    end else if (start) begin
      if (base_addr[1:0] != 2'b00) m_err = 1;
      else begin
        m_err = 0; m_addr = base_addr; m_count = 0; m_acc = 1;
      end
    end
  end

  // Observed writes and pulses.
  logic [7:0]      mem [longint unsigned];
  longint unsigned log_a[$];
  logic [7:0]      log_d[$];
  int              done_cnt = 0;

  always @(negedge clk) begin
    logic        e_we;
    logic [63:0] e_addr;
    logic [7:0]  e_data;
    logic [31:0] sh;
    if (chk_en) begin
      e_we   = (m_left > 0);
      e_addr = e_we ? m_addr + 64'(4 - m_left) : '0;
      sh     = e_we ? m_word >> (8 * (m_left - 1)) : '0;
      e_data = sh[7:0];
      tests++;
      if (mem_we !== e_we || mem_waddr !== e_addr || mem_wdata !== e_data ||
          in_ready !== m_acc || busy !== (m_acc || e_we) || done !== m_done ||
          error !== m_err || word_count !== CW'(m_count)) begin
        fails++;
        $display("FAIL cycle_compare t=%0t got we=%b addr=%h data=%h rdy=%b busy=%b done=%b err=%b cnt=%0d want we=%b addr=%h data=%h rdy=%b busy=%b done=%b err=%b cnt=%0d",
                 $time, mem_we, mem_waddr, mem_wdata, in_ready, busy, done, error, word_count,
                 e_we, e_addr, e_data, m_acc, m_acc || e_we, m_done, m_err, m_count);
      end
      if (mem_we === 1'b1) begin
        log_a.push_back(mem_waddr);
        log_d.push_back(mem_wdata);
        mem[mem_waddr] = mem_wdata;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fetch(input longint unsigned a);
    if (mem.exists(a) && mem.exists(a + 1) && mem.exists(a + 2) && mem.exists(a + 3))
      return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
    return 'x;
  endfunction

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [63:0] b);
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit l);
    int tries = 0;
    bit sent = 0;
    in_instr = w;
    in_last  = l;
    while (!sent && tries < 200) begin
      in_valid = ($urandom_range(0, 2) != 0);
      sent = in_valid && in_ready;
      @(posedge clk); #1;
      tries++;
    end
    in_valid = 1'b0;
    check("handshake_done", 64'(sent), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 100) begin
      in_valid = $urandom_range(0, 1);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("idle_within_bound", 64'(n < 100), 64'd1);
  endtask

  initial begin
    logic [31:0] w3[3];
    longint unsigned b;

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_err_done_busy", 64'({error, done, busy}), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single word at 0x10.
    clear_log();
    pulse_start(64'h10);
    send_word(32'hDEADBEEF, 1'b1);
    wait_idle();
    check("single_nbytes", 64'(log_a.size()), 64'd4);
    if (log_a.size() == 4) begin
      check("single_a0", {log_a[0], log_d[0]}, {64'h10, 8'hDE});
      check("single_a3", {log_a[3], log_d[3]}, {64'h13, 8'hEF});
    end
    check("single_done", 64'(done_cnt), 64'd1);
    check("single_count", 64'(word_count), 64'd1);
    check("single_fetch", 64'(fetch(64'h10)), 64'hDEADBEEF);

    // Three-word stream with random in_valid.
    clear_log();
    b = 64'($urandom_range(0, 1000)) * 4;
    for (int i = 0; i < 3; i++) w3[i] = $urandom;
    pulse_start(b);
    for (int i = 0; i < 3; i++) send_word(w3[i], i == 2);
    wait_idle();
    check("three_count", 64'(word_count), 64'd3);
    check("three_nbytes", 64'(log_a.size()), 64'd12);
    for (int i = 0; i < 12 && i < log_a.size(); i++)
      check("three_addr_seq", log_a[i], b + 64'(i));
    for (int i = 0; i < 3; i++) check("three_fetch", 64'(fetch(b + 64'(4 * i))), 64'(w3[i]));

    // Misaligned start.
    clear_log();
    pulse_start(64'h102);
    check("misalign_err", 64'(error), 64'd1);
    check("misalign_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("misalign_nowrite", 64'(log_a.size()), 64'd0);
    check("misalign_sticky", 64'(error), 64'd1);

    // Restart from ERROR.
    clear_log();
    pulse_start(64'h0);
    check("restart_err_clear", 64'(error), 64'd0);
    send_word($urandom, 1'b1);
    wait_idle();
    check("restart_done", 64'(done_cnt), 64'd1);
    check("restart_count", 64'(word_count), 64'd1);

    // Overflow at the top of memory.
    clear_log();
    pulse_start(64'hFF8);
    for (int i = 0; i < 3; i++) send_word($urandom, i == 2);
    wait_idle();
    check("ovf_nbytes", 64'(log_a.size()), 64'd8);
    if (log_a.size() == 8) check("ovf_last_addr", log_a[7], 64'hFFF);
    check("ovf_err", 64'(error), 64'd1);
    check("ovf_no_done", 64'(done_cnt), 64'd0);
    check("ovf_count", 64'(word_count), 64'd2);

    // Reset on the second byte of a word.
    pulse_start(64'h40);
    send_word(32'h12345678, 1'b0);
    @(posedge clk); #1;
    check("midrst_byte1", {mem_waddr, mem_wdata}, {64'h41, 8'h34});
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_we", 64'(mem_we), 64'd0);
    check("midrst_outs", 64'({in_ready, busy, done, error}), 64'd0);
    check("midrst_addr_data", {mem_waddr, mem_wdata}, '0);
    check("midrst_count", 64'(word_count), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Random sessions.
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 4);
      pulse_start(64'($urandom_range(0, 1020)) * 4);
      for (int i = 0; i < n; i++) send_word($urandom, i == n - 1);
      wait_idle();
    end

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
